// File: rtl/placement_strip_allocator_if.sv
// Request/result bundle for the placement strip allocator: one request channel
// in, one registered result record out.
interface placement_strip_allocator_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_width;
    logic       out_valid;
    logic       strike_flag_write;
    logic [3:0] strip_ID_write;
    logic [7:0] old_occupied_width_write;
    logic [7:0] new_occupied_width_write;
    logic       req_fail;

    modport master (
        output req_valid,
        output req_width,
        input  req_ready,
        input  out_valid,
        input  strike_flag_write,
        input  strip_ID_write,
        input  old_occupied_width_write,
        input  new_occupied_width_write,
        input  req_fail
    );

    modport slave (
        input  req_valid,
        input  req_width,
        output req_ready,
        output out_valid,
        output strike_flag_write,
        output strip_ID_write,
        output old_occupied_width_write,
        output new_occupied_width_write,
        output req_fail
    );
endinterface

// File: rtl/placement_strip_allocator.sv
// First-fit placement of program widths into NUM_STRIPS strips of STRIP_CAP
// capacity, scanning one strip per cycle and reporting a single result record.
module placement_strip_allocator #(
    parameter int NUM_STRIPS = 14,
    parameter int STRIP_CAP  = 200
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear_all,
    input  logic [3:0]                  occ_rd_id,
    output logic [7:0]                  occ_rd_data,
    placement_strip_allocator_if.slave  pif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_STRIPS - 1);
    localparam logic [8:0] CAP9     = 9'(STRIP_CAP);

    state_t     state_q, state_d;
    logic [7:0] occ_q [NUM_STRIPS];
    logic [7:0] width_q;
    logic [3:0] idx_q, idx_d;

    logic [7:0] occ_k;
    logic [8:0] sum_k;
    logic       fit_k;
    logic       bad_width;
    logic       accept;
    logic       latch_width;
    logic       load_ok;
    logic       load_fail;
    logic       occ_we;

    logic       strike_q;
    logic [3:0] strip_id_q;
    logic [7:0] old_w_q;
    logic [7:0] new_w_q;

    // Strip under examination; the 9-bit sum keeps an overflowing fit from wrapping.
    always_comb begin
        occ_k = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            if (idx_q == 4'(i)) occ_k = occ_q[i];
        end
    end

    assign sum_k     = {1'b0, occ_k} + {1'b0, width_q};
    assign fit_k     = (sum_k <= CAP9);
    assign bad_width = (pif.req_width == 8'd0) || ({1'b0, pif.req_width} > CAP9);

    assign pif.req_ready = (state_q == IDLE) && !clear_all;
    assign accept        = pif.req_valid && pif.req_ready;

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        latch_width = 1'b0;
        load_ok     = 1'b0;
        load_fail   = 1'b0;
        occ_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_width) begin
                        state_d   = ISSUE;
                        load_fail = 1'b1;
                    end else begin
                        state_d     = SCAN;
                        idx_d       = '0;
                        latch_width = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (fit_k) begin
                    state_d = ISSUE;
                    load_ok = 1'b1;
                    occ_we  = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d   = ISSUE;
                    load_fail = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear wins over everything, including a fit found on this very edge.
        if (clear_all) begin
            state_d     = IDLE;
            latch_width = 1'b0;
            load_ok     = 1'b0;
            load_fail   = 1'b0;
            occ_we      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch_width) width_q <= pif.req_width;
        end
    end

    // NOTE: the occupancy array is a small flop bank, not RAM, so it is reset explicitly to give empty strips.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_STRIPS; i++) occ_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                if (clear_all) begin
                    occ_q[i] <= '0;
                end else if (occ_we && (idx_q == 4'(i))) begin
                    occ_q[i] <= sum_k[7:0];
                end
            end
        end
    end

    // Result record is loaded on the edge entering ISSUE and held until the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strike_q   <= 1'b0;
            strip_id_q <= '0;
            old_w_q    <= '0;
            new_w_q    <= '0;
        end else if (load_ok) begin
            strike_q   <= 1'b1;
            strip_id_q <= idx_q;
            old_w_q    <= occ_k;
            new_w_q    <= sum_k[7:0];
        end else if (load_fail) begin
            strike_q   <= 1'b0;
            strip_id_q <= 4'hF;
            old_w_q    <= '0;
            new_w_q    <= '0;
        end
    end

    assign pif.out_valid                = (state_q == ISSUE);
    assign pif.req_fail                 = (state_q == ISSUE) && !strike_q;
    assign pif.strike_flag_write        = strike_q;
    assign pif.strip_ID_write           = strip_id_q;
    assign pif.old_occupied_width_write = old_w_q;
    assign pif.new_occupied_width_write = new_w_q;

    always_comb begin
        occ_rd_data = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            if (occ_rd_id == 4'(i)) occ_rd_data = occ_q[i];
        end
    end

endmodule

// File: tb/tb_placement_strip_allocator.sv
// Scoreboard bench for placement_strip_allocator: a first-fit model predicts each
// result and its cycle; a negedge monitor compares every out_valid pulse.
module tb_placement_strip_allocator;

    localparam int NUM = 14;
    localparam int CAP = 200;

    typedef struct {
        bit         strike;
        logic [3:0] id;
        logic [7:0] old_w;
        logic [7:0] new_w;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       clear_all;
    logic [3:0] occ_rd_id;
    logic [7:0] occ_rd_data;

    placement_strip_allocator_if pif();

    placement_strip_allocator #(.NUM_STRIPS(NUM), .STRIP_CAP(CAP)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clear_all   (clear_all),
        .occ_rd_id   (occ_rd_id),
        .occ_rd_data (occ_rd_data),
        .pif         (pif)
    );

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] m_occ [NUM];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // First-fit reference: predicts the record and the cycle of its out_valid.
    function automatic exp_t model_req(input logic [7:0] w, input int t);
        exp_t e;
        bit   found = 1'b0;
        e.strike = 1'b0;
        e.id     = 4'hF;
        e.old_w  = 8'd0;
        e.new_w  = 8'd0;
        if (w == 8'd0 || int'(w) > CAP) begin
            e.cyc = t + 1;
        end else begin
            e.cyc = t + 1 + NUM;
            for (int k = 0; k < NUM; k++) begin
                if (!found && (int'(m_occ[k]) + int'(w) <= CAP)) begin
                    found    = 1'b1;
                    e.strike = 1'b1;
                    e.id     = 4'(k);
                    e.old_w  = m_occ[k];
                    e.new_w  = m_occ[k] + w;
                    m_occ[k] = e.new_w;
                    e.cyc    = t + 2 + k;
                end
            end
        end
        return e;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < NUM; k++) m_occ[k] = 8'd0;
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && pif.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (pif.strike_flag_write !== mon_e.strike || pif.strip_ID_write !== mon_e.id ||
                    pif.old_occupied_width_write !== mon_e.old_w ||
                    pif.new_occupied_width_write !== mon_e.new_w ||
                    pif.req_fail !== !mon_e.strike || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL result: got strike=%0b id=%0h old=%0d new=%0d fail=%0b cyc=%0d, required strike=%0b id=%0h old=%0d new=%0d fail=%0b cyc=%0d",
                             pif.strike_flag_write, pif.strip_ID_write, pif.old_occupied_width_write,
                             pif.new_occupied_width_write, pif.req_fail, cyc, mon_e.strike, mon_e.id,
                             mon_e.old_w, mon_e.new_w, !mon_e.strike, mon_e.cyc);
                end
            end
        end
    end

    // Returns at the negedge after the accepting edge; acc_cyc is cycle T.
    task automatic send_req(input logic [7:0] w, input bit track, output int acc_cyc);
        int n = 0;
        @(negedge clk);
        while (pif.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        acc_cyc = cyc;
        if (pif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: got req_ready=%0b after %0d cycles, required 1", pif.req_ready, n);
            return;
        end
        pif.req_valid = 1'b1;
        pif.req_width = w;
        if (track) sb.push_back(model_req(w, cyc));
        @(negedge clk);
        pif.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic verify_occupancy(input string tag);
        logic [7:0] want;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            occ_rd_id = 4'(i);
            #1;
            want = (i < NUM) ? m_occ[i] : 8'd0;
            checks++;
            if (occ_rd_data !== want) begin
                errors++;
                $display("FAIL occ_%s[%0d]: got %0d, required %0d", tag, i, occ_rd_data, want);
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        model_zero();
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (pif.out_valid !== 1'b0 || pif.req_fail !== 1'b0 || pif.strike_flag_write !== 1'b0 ||
            pif.strip_ID_write !== 4'h0 || pif.old_occupied_width_write !== 8'd0 ||
            pif.new_occupied_width_write !== 8'd0) begin
            errors++;
            $display("FAIL %s_outputs: got valid=%0b fail=%0b strike=%0b id=%0h old=%0d new=%0d, required all 0",
                     tag, pif.out_valid, pif.req_fail, pif.strike_flag_write, pif.strip_ID_write,
                     pif.old_occupied_width_write, pif.new_occupied_width_write);
        end
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        clear_all     = 1'b0;
        occ_rd_id     = 4'd0;
        pif.req_valid = 1'b0;
        pif.req_width = 8'd0;
        model_zero();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        #1;
        checks++;
        if (pif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b, required 1", pif.req_ready);
        end
        verify_occupancy("reset");
    endtask

    task automatic test_single();
        int t;
        send_req(8'd50, 1'b1, t);
        wait_drain(40);
        verify_occupancy("single");
    endtask

    task automatic test_second_strip();
        int t;
        do_clear();
        send_req(8'd200, 1'b1, t);
        send_req(8'd10, 1'b1, t);
        wait_drain(40);
        verify_occupancy("second");
    endtask

    task automatic test_full_fail();
        int t;
        do_clear();
        for (int i = 0; i < NUM; i++) send_req(8'd200, 1'b1, t);
        send_req(8'd1, 1'b1, t);
        wait_drain(60);
        verify_occupancy("full");
    endtask

    task automatic test_bad_width();
        int t;
        send_req(8'd201, 1'b1, t);
        send_req(8'd0, 1'b1, t);
        send_req(8'd255, 1'b1, t);
        wait_drain(40);
        verify_occupancy("badw");
    endtask

    task automatic test_exact_fit();
        int t;
        do_clear();
        send_req(8'd150, 1'b1, t);
        send_req(8'd50, 1'b1, t);
        send_req(8'd1, 1'b1, t);
        send_req(8'd199, 1'b1, t);
        send_req(8'd2, 1'b1, t);
        wait_drain(60);
        verify_occupancy("exact");
    endtask

    task automatic test_clear_abort();
        int t;
        do_clear();
        for (int i = 0; i < 3; i++) send_req(8'd200, 1'b1, t);
        wait_drain(60);
        send_req(8'd50, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        model_zero();
        #1;
        checks++;
        if (pif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_idle: got req_ready=%0b at cycle %0d (T=%0d), required 1", pif.req_ready, cyc, t);
        end
        repeat (20) @(negedge clk);
        verify_occupancy("clear");
        send_req(8'd50, 1'b1, t);
        wait_drain(40);
    endtask

    task automatic test_pending_clear();
        @(negedge clk);
        clear_all     = 1'b1;
        pif.req_valid = 1'b1;
        pif.req_width = 8'd30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pif.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL pending_ready: got %0b while clearing, required 0", pif.req_ready);
            end
        end
        clear_all = 1'b0;
        model_zero();
        sb.push_back(model_req(8'd30, cyc));
        @(negedge clk);
        pif.req_valid = 1'b0;
        wait_drain(40);
        verify_occupancy("pending");
    endtask

    task automatic test_reset_mid_scan();
        int t;
        do_clear();
        for (int i = 0; i < 4; i++) send_req(8'd200, 1'b1, t);
        wait_drain(60);
        send_req(8'd50, 1'b0, t);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs_zero("midscan_reset");
        model_zero();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (pif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midscan_ready: got %0b after release, required 1", pif.req_ready);
        end
        repeat (20) @(negedge clk);
        verify_occupancy("midscan");
    endtask

    task automatic test_back_to_back();
        int t;
        logic [7:0] w;
        do_clear();
        for (int i = 0; i < 30; i++) begin
            w = 8'($urandom_range(0, 215));
            send_req(w, 1'b1, t);
        end
        wait_drain(600);
        verify_occupancy("b2b");
    endtask

    initial begin
        test_reset();
        test_single();
        test_second_strip();
        test_full_fail();
        test_bad_width();
        test_exact_fit();
        test_clear_abort();
        test_pending_clear();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
